// File: rtl/gpio_port.sv
// rtl/gpio_port.sv - memory-mapped GPIO port with set/clear/toggle, edge capture and maskable irq
module gpio_port #(
    parameter logic [31:0] ADDR  = 32'h0100_0000,
    parameter int          WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             mem_valid,
    input  logic             mem_ready,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    input  logic [3:0]       wstrb,
    output logic             mem_port_ready,
    output logic [31:0]      rdata,
    output logic [WIDTH-1:0] odata,
    output logic [WIDTH-1:0] oe,
    input  logic [WIDTH-1:0] idata,
    output logic             irq
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACK  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    localparam logic [2:0] REG_DATA = 3'd0;
    localparam logic [2:0] REG_DIR  = 3'd1;
    localparam logic [2:0] REG_IN   = 3'd2;
    localparam logic [2:0] REG_SET  = 3'd3;
    localparam logic [2:0] REG_CLR  = 3'd4;
    localparam logic [2:0] REG_TGL  = 3'd5;
    localparam logic [2:0] REG_EDGE = 3'd6;
    localparam logic [2:0] REG_MASK = 3'd7;

    state_t           state;
    logic [WIDTH-1:0] mask_r;
    logic [WIDTH-1:0] edge_r;
    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] sync3;

    logic             hit;
    logic             accept;
    logic             wr;
    logic [2:0]       idx;
    logic [31:0]      byte_mask;
    logic [WIDTH-1:0] wm;
    logic [WIDTH-1:0] wbits;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] odata_n;
    logic [WIDTH-1:0] oe_n;
    logic [WIDTH-1:0] mask_n;
    logic [WIDTH-1:0] edge_clr;
    logic [WIDTH-1:0] edge_n;
    logic [31:0]      rd_word;

    // addr[1:0] and wdata bits above WIDTH are intentionally don't-care
    logic unused_bits;
    assign unused_bits = ^{addr[1:0], wdata};

    assign hit       = mem_valid && (addr[31:5] == ADDR[31:5]);
    assign accept    = (state == S_IDLE) && hit && !mem_ready;
    assign wr        = accept && (wstrb != 4'b0000);
    assign idx       = addr[4:2];
    assign byte_mask = {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
    assign wm        = byte_mask[WIDTH-1:0];
    assign wbits     = wdata[WIDTH-1:0] & wm;
    assign rise      = sync2 & ~sync3;
    // a fresh rising edge beats a simultaneous write-one-to-clear
    assign edge_n    = (edge_r & ~edge_clr) | rise;

    // next-state of the writable registers for the accepted write
    always_comb begin
        odata_n  = odata;
        oe_n     = oe;
        mask_n   = mask_r;
        edge_clr = '0;
        if (wr) begin
            case (idx)
                REG_DATA: odata_n  = (odata & ~wm) | wbits;
                REG_DIR:  oe_n     = (oe & ~wm) | wbits;
                REG_SET:  odata_n  = odata | wbits;
                REG_CLR:  odata_n  = odata & ~wbits;
                REG_TGL:  odata_n  = odata ^ wbits;
                REG_EDGE: edge_clr = wbits;
                REG_MASK: mask_n   = (mask_r & ~wm) | wbits;
                default:  ;
            endcase
        end
    end

    // read mux, zero-extended; write-only registers read back as zero
    always_comb begin
        rd_word = '0;
        case (idx)
            REG_DATA: rd_word[WIDTH-1:0] = odata;
            REG_DIR:  rd_word[WIDTH-1:0] = oe;
            REG_IN:   rd_word[WIDTH-1:0] = sync2;
            REG_EDGE: rd_word[WIDTH-1:0] = edge_r;
            REG_MASK: rd_word[WIDTH-1:0] = mask_r;
            default:  rd_word = '0;
        endcase
    end

    // bus handshake: one ready pulse per request, then wait for mem_valid to drop
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state          <= S_IDLE;
            mem_port_ready <= 1'b0;
            rdata          <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    mem_port_ready <= 1'b0;
                    rdata          <= '0;
                    if (accept) begin
                        state          <= S_ACK;
                        mem_port_ready <= 1'b1;
                        rdata          <= rd_word;
                    end
                end
                S_ACK: begin
                    state          <= S_WAIT;
                    mem_port_ready <= 1'b0;
                    rdata          <= '0;
                end
                S_WAIT: begin
                    mem_port_ready <= 1'b0;
                    rdata          <= '0;
                    if (!mem_valid) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state          <= S_IDLE;
                    mem_port_ready <= 1'b0;
                    rdata          <= '0;
                end
            endcase
        end
    end

    // register file, input synchroniser, edge capture and interrupt
    always_ff @(posedge clk) begin
        if (!resetn) begin
            odata  <= '0;
            oe     <= '0;
            mask_r <= '0;
            edge_r <= '0;
            sync1  <= '0;
            sync2  <= '0;
            sync3  <= '0;
            irq    <= 1'b0;
        end else begin
            odata  <= odata_n;
            oe     <= oe_n;
            mask_r <= mask_n;
            edge_r <= edge_n;
            sync1  <= idata;
            sync2  <= sync1;
            sync3  <= sync2;
            irq    <= |(edge_r & mask_r);
        end
    end

endmodule

// File: tb/tb_gpio_port.sv
// tb/tb_gpio_port.sv - self-checking bench for gpio_port
module tb_gpio_port;

    localparam logic [31:0] BASE  = 32'h0100_0000;
    localparam int          WIDTH = 8;

    logic             clk;
    logic             resetn;
    logic             mem_valid;
    logic             mem_ready;
    logic [31:0]      addr;
    logic [31:0]      wdata;
    logic [3:0]       wstrb;
    logic             mem_port_ready;
    logic [31:0]      rdata;
    logic [WIDTH-1:0] odata;
    logic [WIDTH-1:0] oe;
    logic [WIDTH-1:0] idata;
    logic             irq;

    int          checks;
    int          failures;
    int          ready_cnt;
    logic [31:0] exp_q[$];
    logic [7:0]  model_odata;

    gpio_port #(.ADDR(BASE), .WIDTH(WIDTH)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .mem_valid      (mem_valid),
        .mem_ready      (mem_ready),
        .addr           (addr),
        .wdata          (wdata),
        .wstrb          (wstrb),
        .mem_port_ready (mem_port_ready),
        .rdata          (rdata),
        .odata          (odata),
        .oe             (oe),
        .idata          (idata),
        .irq            (irq)
    );

    assign mem_ready = mem_port_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_port_ready) ready_cnt++;
    end

    function automatic logic [31:0] reg_addr(input int idx);
        return BASE + 32'(idx * 4);
    endfunction

    // Issue one transfer; reads push their expected data and pop it on ready.
    task automatic bus_op(input int idx, input logic [31:0] d, input logic [3:0] s,
                          input int hold, input string name);
        int          lat;
        logic [31:0] exp;
        if (s == 4'h0) exp_q.push_back(d);
        addr = reg_addr(idx); wdata = (s == 4'h0) ? 32'h0 : d; wstrb = s; mem_valid = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!mem_port_ready && lat < 8);
        checks++;
        if (lat !== 1 || mem_port_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s latency: got %0d cycles (ready=%b), want 1", name, lat, mem_port_ready);
        end
        if (s == 4'h0) begin
            exp = exp_q.pop_front();
            checks++;
            if (rdata !== exp) begin
                failures++;
                $display("FAIL %s rdata: got %h, want %h", name, rdata, exp);
            end
        end
        repeat (hold) @(negedge clk);
        mem_valid = 1'b0; wstrb = 4'h0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (odata !== 8'h00) begin failures++; $display("FAIL reset_odata: got %h, want 00", odata); end
        checks++; if (oe !== 8'h00) begin failures++; $display("FAIL reset_oe: got %h, want 00", oe); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq: got %b, want 0", irq); end
        checks++; if (mem_port_ready !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b, want 0", mem_port_ready); end
        checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata: got %h, want 0", rdata); end
        resetn = 1'b1;
        @(negedge clk);
        model_odata = 8'h00;
    endtask

    task automatic test_write_hold();
        int c0;
        c0 = ready_cnt;
        bus_op(0, 32'h0000_00AB, 4'hF, 2, "data_write_held");
        model_odata = 8'hAB;
        checks++; if (ready_cnt - c0 !== 1) begin failures++; $display("FAIL single_ack: got %0d pulses, want 1", ready_cnt - c0); end
        checks++; if (odata !== model_odata) begin failures++; $display("FAIL data_write: got %h, want %h", odata, model_odata); end
        checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL rdata_idle: got %h, want 0", rdata); end
    endtask

    task automatic test_set_clr_tgl();
        bus_op(3, 32'h04, 4'hF, 0, "set");
        model_odata = model_odata | 8'h04;
        checks++; if (odata !== model_odata) begin failures++; $display("FAIL set: got %h, want %h", odata, model_odata); end
        bus_op(4, 32'h01, 4'hF, 0, "clr");
        model_odata = model_odata & ~8'h01;
        checks++; if (odata !== model_odata) begin failures++; $display("FAIL clr: got %h, want %h", odata, model_odata); end
        bus_op(5, 32'hF0, 4'hF, 0, "tgl");
        model_odata = model_odata ^ 8'hF0;
        checks++; if (odata !== model_odata) begin failures++; $display("FAIL tgl: got %h, want %h", odata, model_odata); end
        bus_op(0, {24'h0, model_odata}, 4'h0, 0, "data_read");
        bus_op(3, 32'h0, 4'h0, 0, "set_read_zero");
        bus_op(1, 32'h0F, 4'hF, 0, "dir_write");
        checks++; if (oe !== 8'h0F) begin failures++; $display("FAIL dir: got %h, want 0F", oe); end
    endtask

    task automatic test_edge_irq();
        idata = 8'h08;
        repeat (3) @(negedge clk);
        bus_op(6, 32'h08, 4'h0, 0, "edge_read");
        bus_op(2, 32'h08, 4'h0, 0, "in_read");
        bus_op(2, 32'hFF, 4'hF, 0, "in_write_ignored");
        bus_op(2, 32'h08, 4'h0, 0, "in_read_after_write");
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_masked: got %b, want 0", irq); end
        bus_op(7, 32'h08, 4'hF, 0, "mask_write");
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_set: got %b, want 1", irq); end
        bus_op(6, 32'h08, 4'hF, 0, "edge_w1c");
        bus_op(6, 32'h00, 4'h0, 0, "edge_cleared");
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_clear: got %b, want 0", irq); end
    endtask

    task automatic test_edge_race_strobe();
        idata = 8'h00;
        repeat (4) @(negedge clk);
        idata = 8'h08;
        repeat (2) @(negedge clk);
        bus_op(6, 32'h08, 4'hF, 0, "edge_race_w1c");
        bus_op(6, 32'h08, 4'h0, 0, "edge_race_read");
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_race: got %b, want 1", irq); end
        bus_op(0, 32'h0000_FF00, 4'h2, 0, "data_strobe");
        checks++; if (odata !== model_odata) begin failures++; $display("FAIL strobe: got %h, want %h", odata, model_odata); end
        bus_op(0, 32'h0000_0033, 4'h1, 0, "data_strobe_b0");
        model_odata = 8'h33;
        checks++; if (odata !== model_odata) begin failures++; $display("FAIL strobe_b0: got %h, want %h", odata, model_odata); end
    endtask

    task automatic test_reset_mid_and_miss();
        int c0;
        int lat;
        addr = reg_addr(0); wdata = 32'h55; wstrb = 4'hF; mem_valid = 1'b1;
        @(negedge clk);
        checks++; if (mem_port_ready !== 1'b1 || odata !== 8'h55) begin
            failures++; $display("FAIL pre_reset_ack: got ready=%b odata=%h, want 1 55", mem_port_ready, odata);
        end
        resetn = 1'b0;
        @(negedge clk);
        checks++; if (mem_port_ready !== 1'b0 || odata !== 8'h00 || rdata !== 32'h0) begin
            failures++; $display("FAIL mid_reset: got ready=%b odata=%h rdata=%h, want 0 00 0", mem_port_ready, odata, rdata);
        end
        resetn = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!mem_port_ready && lat < 8);
        checks++; if (mem_port_ready !== 1'b1 || lat !== 1 || odata !== 8'h55) begin
            failures++; $display("FAIL reaccept: got ready=%b lat=%0d odata=%h, want 1 1 55", mem_port_ready, lat, odata);
        end
        mem_valid = 1'b0; wstrb = 4'h0;
        repeat (2) @(negedge clk);
        c0 = ready_cnt;
        addr = 32'h0200_0000; wdata = 32'hFF; wstrb = 4'hF; mem_valid = 1'b1;
        repeat (4) @(negedge clk);
        mem_valid = 1'b0; wstrb = 4'h0;
        repeat (2) @(negedge clk);
        checks++; if (ready_cnt !== c0 || odata !== 8'h55) begin
            failures++; $display("FAIL miss: got pulses=%0d odata=%h, want 0 55", ready_cnt - c0, odata);
        end
    endtask

    initial begin
        checks = 0; failures = 0; ready_cnt = 0;
        mem_valid = 1'b0; addr = 32'h0; wdata = 32'h0; wstrb = 4'h0; idata = 8'h00;
        resetn = 1'b0;
        test_reset();
        test_write_hold();
        test_set_clr_tgl();
        test_edge_irq();
        test_edge_race_strobe();
        test_reset_mid_and_miss();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
